// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator bus controller: FSM encoding, op codes, data width.
package acc_pkg;

    localparam int unsigned ACC_DW = 8;

    localparam logic OP_READ = 1'b1;
    localparam logic OP_ADD  = 1'b0;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StGrant = 2'd1,
        StBus   = 2'd2,
        StAck   = 2'd3
    } state_e;

endpackage

// File: rtl/acc_arb2.sv
// Two-requester arbiter: one-hot grant; on a tie the requester named by ptr wins.
module acc_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/acc_bus_ctrl.sv
// Arbitrates two requesters onto a shared accumulator bus (read or add, 4 cycles per transfer).
// Define ACC_BUS_CTRL_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module acc_bus_ctrl
    import acc_pkg::*;
#(
    parameter int unsigned DW = ACC_DW
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic [1:0]    Req,
    input  logic [1:0]    Op,
    input  logic [DW-1:0] WrData0,
    input  logic [DW-1:0] WrData1,
    output logic [1:0]    Ack,
    output logic [DW-1:0] RdData,
    output logic          Busy,
    output logic          Sel,
    output logic          RnW,
    inout  wire  [DW-1:0] Dio
);

    state_e        state_q, state_d;
    logic          win_q, win_d;
    logic          op_q, op_d;
    logic [DW-1:0] data_q, data_d;
    logic [DW-1:0] rd_q, rd_d;
    logic          ptr;
    logic [1:0]    gnt;

`ifdef ACC_BUS_CTRL_RR_EN
    logic ptr_q, ptr_d;

    // After serving a requester, favour the other one on the next tie.
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == StAck) begin
            ptr_d = ~win_q;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = 1'b0;
`endif

    acc_arb2 u_arb (
        .req (Req),
        .ptr (ptr),
        .gnt (gnt)
    );

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        op_d    = op_q;
        data_d  = data_q;
        rd_d    = rd_q;
        unique case (state_q)
            StIdle: begin
                if (|Req) begin
                    // Snapshot the winner's request so later input changes are ignored.
                    state_d = StGrant;
                    win_d   = gnt[1];
                    op_d    = Op[gnt[1]];
                    data_d  = gnt[1] ? WrData1 : WrData0;
                end
            end
            StGrant: state_d = StBus;
            StBus: begin
                state_d = StAck;
                if (op_q == OP_READ) begin
                    rd_d = Dio;
                end
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= StIdle;
            win_q   <= 1'b0;
            op_q    <= OP_READ;
            data_q  <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            op_q    <= op_d;
            data_q  <= data_d;
            rd_q    <= rd_d;
        end
    end

    assign Sel    = (state_q == StBus);
    assign RnW    = Sel ? op_q : 1'b1;
    assign Busy   = (state_q != StIdle);
    assign Ack    = (state_q == StAck) ? (win_q ? 2'b10 : 2'b01) : 2'b00;
    assign RdData = rd_q;
    assign Dio    = (Sel && (op_q == OP_ADD)) ? data_q : {DW{1'bz}};

endmodule

// File: tb/tb_acc_bus_ctrl.sv
// Directed self-checking bench for acc_bus_ctrl; ACC_BUS_CTRL_RR_EN selects round-robin expectations.
module tb_acc_bus_ctrl;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [1:0] op;
    logic [7:0] wr0;
    logic [7:0] wr1;
    logic [1:0] ack;
    logic [7:0] rd_data;
    logic       busy;
    logic       sel;
    logic       rnw;
    wire  [7:0] dio;

    logic [7:0] mem_val;
    logic [7:0] slave_val;
    logic       mon_en;
    int         checks;
    int         errors;

    // Bus slave model: returns mem_val during reads, parks 0x00 otherwise, releases during writes.
    assign slave_val = (sel && rnw) ? mem_val : 8'h00;
    assign dio = (sel && !rnw) ? 8'hzz : slave_val;

    acc_bus_ctrl #(.DW(8)) dut (
        .Clk     (clk),
        .Rst     (rst),
        .Req     (req),
        .Op      (op),
        .WrData0 (wr0),
        .WrData1 (wr1),
        .Ack     (ack),
        .RdData  (rd_data),
        .Busy    (busy),
        .Sel     (sel),
        .RnW     (rnw),
        .Dio     (dio)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Any controller drive outside a write strobe corrupts the slave's value on dio.
    always @(negedge clk) begin
        if (mon_en && !(sel && !rnw)) begin
            checks++;
            if (dio !== slave_val) begin
                errors++;
                $display("FAIL contention: dio=%h want %h (sel=%b rnw=%b)", dio, slave_val, sel, rnw);
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #3;
        checks++; if (sel !== 1'b0) begin errors++; $display("FAIL reset_sel: got %b want 0", sel); end
        checks++; if (rnw !== 1'b1) begin errors++; $display("FAIL reset_rnw: got %b want 1", rnw); end
        checks++; if (ack !== 2'b00) begin errors++; $display("FAIL reset_ack: got %b want 00", ack); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd: got %h want 00", rd_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (dio !== 8'h00) begin errors++; $display("FAIL reset_dio: got %h want 00", dio); end
        step;
        rst = 1'b0;
        step;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy %b want 0", busy); end
        mon_en = 1'b1;
    endtask

    task automatic test_write;
        req = 2'b01; op = 2'b00; wr0 = 8'h05; wr1 = 8'h00;
        step;  // edge n: GRANT
        wr0 = 8'hFF;
        checks++; if (busy !== 1'b1 || sel !== 1'b0) begin errors++;
            $display("FAIL wr_grant: busy=%b sel=%b want 1 0", busy, sel); end
        step;  // BUS
        checks++; if (sel !== 1'b1 || rnw !== 1'b0) begin errors++;
            $display("FAIL wr_bus_strobe: sel=%b rnw=%b want 1 0", sel, rnw); end
        checks++; if (dio !== 8'h05) begin errors++; $display("FAIL wr_bus_dio: got %h want 05", dio); end
        checks++; if (ack !== 2'b00) begin errors++; $display("FAIL wr_bus_ack: got %b want 00", ack); end
        step;  // ACK, request still held
        checks++; if (ack !== 2'b01 || sel !== 1'b0 || rnw !== 1'b1) begin errors++;
            $display("FAIL wr_ack: ack=%b sel=%b rnw=%b want 01 0 1", ack, sel, rnw); end
        step;  // IDLE: must not have restarted
        checks++; if (busy !== 1'b0 || ack !== 2'b00) begin errors++;
            $display("FAIL wr_no_restart: busy=%b ack=%b want 0 00", busy, ack); end
        req = 2'b00;
        step;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_idle: busy %b want 0", busy); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL wr_rd_hold: got %h want 00", rd_data); end
    endtask

    task automatic test_read;
        req = 2'b10; op = 2'b10; wr1 = 8'h18; mem_val = 8'hA7;
        step;  // GRANT
        op = 2'b00;
        step;  // BUS
        checks++; if (sel !== 1'b1 || rnw !== 1'b1) begin errors++;
            $display("FAIL rd_bus_strobe: sel=%b rnw=%b want 1 1", sel, rnw); end
        checks++; if (dio !== 8'hA7) begin errors++; $display("FAIL rd_bus_dio: got %h want a7", dio); end
        step;  // ACK
        checks++; if (ack !== 2'b10) begin errors++; $display("FAIL rd_ack: got %b want 10", ack); end
        checks++; if (rd_data !== 8'hA7) begin errors++; $display("FAIL rd_data: got %h want a7", rd_data); end
        req = 2'b00;
        step;
        mem_val = 8'h00;
        step;
        checks++; if (busy !== 1'b0 || ack !== 2'b00) begin errors++;
            $display("FAIL rd_idle: busy=%b ack=%b want 0 00", busy, ack); end
    endtask

    task automatic test_drop;
        req = 2'b10; op = 2'b00; wr1 = 8'h5A; wr0 = 8'h00;
        step;  // GRANT
        step;  // BUS: requester 0 pulses for one cycle
        req = 2'b11;
        checks++; if (dio !== 8'h5A) begin errors++; $display("FAIL drop_dio: got %h want 5a", dio); end
        step;  // ACK
        req = 2'b10;
        checks++; if (ack !== 2'b10) begin errors++; $display("FAIL drop_ack: got %b want 10", ack); end
        req = 2'b00;
        step;  // IDLE
        checks++; if (ack !== 2'b00 || busy !== 1'b0) begin errors++;
            $display("FAIL drop_idle: ack=%b busy=%b want 00 0", ack, busy); end
        step;
        checks++; if (ack !== 2'b00 || busy !== 1'b0) begin errors++;
            $display("FAIL drop_no_ack0: ack=%b busy=%b want 00 0", ack, busy); end
        checks++; if (rd_data !== 8'hA7) begin errors++; $display("FAIL drop_rd_hold: got %h want a7", rd_data); end
    endtask

    task automatic test_arbitration;
        logic [3:0] exp_win;
        logic       w;
`ifdef ACC_BUS_CTRL_RR_EN
        exp_win = 4'b1010;
`else
        exp_win = 4'b0000;
`endif
        req = 2'b11; op = 2'b00; wr0 = 8'h11; wr1 = 8'h22;
        for (int i = 0; i < 4; i++) begin
            w = exp_win[i];
            step;  // GRANT
            step;  // BUS
            checks++; if (dio !== (w ? 8'h22 : 8'h11)) begin errors++;
                $display("FAIL arb_dio[%0d]: got %h want %h", i, dio, w ? 8'h22 : 8'h11); end
            step;  // ACK
            checks++; if (ack !== (w ? 2'b10 : 2'b01)) begin errors++;
                $display("FAIL arb_ack[%0d]: got %b want %b", i, ack, w ? 2'b10 : 2'b01); end
            step;  // IDLE
        end
        req = 2'b00;
        step;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arb_idle: busy %b want 0", busy); end
    endtask

    task automatic test_mid_reset;
        req = 2'b01; op = 2'b00; wr0 = 8'h3C;
        step;  // GRANT
        step;  // BUS
        checks++; if (sel !== 1'b1 || dio !== 8'h3C) begin errors++;
            $display("FAIL mr_bus: sel=%b dio=%h want 1 3c", sel, dio); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (sel !== 1'b0 || rnw !== 1'b1) begin errors++;
            $display("FAIL mr_strobe: sel=%b rnw=%b want 0 1", sel, rnw); end
        checks++; if (dio !== 8'h00) begin errors++; $display("FAIL mr_dio: got %h want 00", dio); end
        checks++; if (ack !== 2'b00 || busy !== 1'b0) begin errors++;
            $display("FAIL mr_ack: ack=%b busy=%b want 00 0", ack, busy); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL mr_rd: got %h want 00", rd_data); end
        req = 2'b00;
        #1;
        rst = 1'b0;
        step;
        checks++; if (busy !== 1'b0 || ack !== 2'b00) begin errors++;
            $display("FAIL mr_idle: busy=%b ack=%b want 0 00", busy, ack); end
        req = 2'b01;  // requester retries after reset
        step; step; step;
        checks++; if (ack !== 2'b01) begin errors++; $display("FAIL mr_retry_ack: got %b want 01", ack); end
        req = 2'b00;
        step;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        mon_en  = 1'b0;
        rst     = 1'b1;
        req     = 2'b00;
        op      = 2'b00;
        wr0     = 8'h00;
        wr1     = 8'h00;
        mem_val = 8'h00;
        test_reset();
        test_write();
        test_read();
        test_drop();
        test_arbitration();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1);
    end

endmodule

// File: doc/acc_bus_ctrl.md
ACC_BUS_CTRL -- requirements
Module: acc_bus_ctrl

Interface
REQ-001 The parameter SHALL be: DW, 8, width of Dio, WrData0, WrData1 and RdData.
REQ-002 The module SHALL have the ports: Clk  input  1  sole clock, rising edge.
REQ-003 The module SHALL have the ports: Rst  input  1  asynchronous, active-high reset.
REQ-004 The module SHALL have the ports: Req  input  2  per-requester request, bit i = requester i, held high until Ack[i].
REQ-005 The module SHALL have the ports: Op  input  2  per-requester operation, 1 = read accumulator, 0 = add WrDatai.
REQ-006 The module SHALL have the ports: WrData0, WrData1  input  DW  add operand of requester 0 or 1.
REQ-007 The module SHALL have the ports: Ack  output  2  one-cycle completion pulse to the served requester.
REQ-008 The module SHALL have the ports: RdData  output  DW  last value read from the accumulator.
REQ-009 The module SHALL have the ports: Busy  output  1  high in every state except IDLE.
REQ-010 The module SHALL have the ports: Sel, RnW  output  1 each  accumulator select and read/not-write strobes.
REQ-011 The module SHALL have the ports: Dio  inout  DW  shared accumulator data bus.

Function
REQ-012 The FSM SHALL have the states IDLE, GRANT, BUS and ACK and SHALL follow IDLE->GRANT when any Req bit is high, GRANT->BUS, BUS->ACK, ACK->IDLE.
REQ-013 On entry to GRANT, the controller SHALL register the winner index, its Op bit and its WrData; input changes after this point SHALL have no effect on the transaction.
REQ-014 In BUS, Sel SHALL be 1 for exactly one cycle and RnW SHALL equal the latched Op.
REQ-015 Dio SHALL be driven with the latched operand only in BUS with RnW=0, and SHALL be high-Z in every other cycle.
REQ-016 For a read, RdData SHALL be loaded from Dio at the clock edge that ends BUS.
REQ-017 In ACK, Ack[winner] SHALL be 1 for exactly one cycle and Sel SHALL be 0.
REQ-018 Latency SHALL be: Req first sampled high in IDLE at edge n -> Sel high in cycle n+2 -> Ack high in cycle n+3 -> IDLE at n+4; throughput SHALL be one transaction per 4 cycles.
REQ-019 A Req bit that drops before it is granted SHALL be ignored, and no Ack SHALL be produced for it.
REQ-020 A Req still high in the cycle of its own Ack SHALL NOT start a second transaction; a new transaction SHALL be arbitrated only after the IDLE state.
REQ-021 When Sel is 0, RnW SHALL be 1.
REQ-022 When not in a read, RdData SHALL hold its value.

Reset
REQ-023 Rst SHALL take effect immediately and independently of Clk, setting: state IDLE, Sel 0, RnW 1, Dio high-Z, Ack 00, RdData 0, Busy 0, priority pointer 0.
REQ-024 Reset asserted mid-transaction SHALL abort the transaction with no Ack, and the requester SHALL re-request after reset.

Configuration
REQ-025 With ACC_BUS_CTRL_RR_EN defined, arbitration SHALL be round-robin: the pointer toggles to the other requester after each Ack, and on simultaneous requests the pointed requester wins.
REQ-026 With ACC_BUS_CTRL_RR_EN undefined, arbitration SHALL be fixed priority with requester 0 always winning ties, and no pointer register SHALL exist.

Structure
REQ-027 The state encoding (2-bit IDLE=0, GRANT=1, BUS=2, ACK=3), the OP_READ/OP_ADD constants and the DW default SHALL live in the shared package acc_pkg.
REQ-028 Arbitration SHALL be a sub-module acc_arb2 (Req, pointer -> one-hot grant), combinational, shared by both configurations.

Verification
REQ-029 After Rst pulse mid-BUS: Sel=0, Dio=Z, Ack=00 and RdData=0 SHALL hold immediately, and the next edge SHALL leave state IDLE.
REQ-030 Req=01, Op=0, WrData0=0x05: in cycle n+2 the bench SHALL observe Sel=1, RnW=0, Dio=0x05 for one cycle, then Ack=01 in cycle n+3.
REQ-031 Req=10, Op[1]=1, with the bench driving Dio=0xA7 while Sel&RnW: the bench SHALL observe Ack=10 and RdData=0xA7, and the controller SHALL never drive Dio.
REQ-032 With RR_EN defined, Req=11 held for 4 transactions: grants SHALL go 0,1,0,1; with RR_EN undefined they SHALL go 0,0,0,0.
REQ-033 Req0 pulsed for one cycle while req1 is in BUS: the bench SHALL observe no Ack[0] and a return to IDLE.
REQ-034 Continuous bus-contention check: the bench SHALL observe Dio never driven by the controller while Sel&RnW.
